// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC router types, default sizes and flit-type decode
package noc_pkg;
    localparam int FLIT_W = 16;
    localparam int NUM_PORTS = 5;
    localparam int CREDITS = 4;
    typedef enum logic [1:0] {BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HEAD_TAIL = 2'b11} flit_type_e;
    typedef enum logic [2:0] {NORTH, SOUTH, EAST, WEST, LOCAL} port_e;
    function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
        return flit_type_e'(flit[FLIT_W-1 -: 2]);
    endfunction
endpackage

// File: rtl/xbar_out_alloc_if.sv
// xbar_out_alloc_if: input-queue, crossbar and credit signals of one output allocator
interface xbar_out_alloc_if #(
    parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int CREDITS = noc_pkg::CREDITS
);
    localparam int CW = $clog2(CREDITS + 1);
    logic [NUM_PORTS-1:0] req_i;
    logic [NUM_PORTS*FLIT_W-1:0] head_flit_i;
    logic credit_i;
    logic [NUM_PORTS-1:0] grant_o;
    logic [NUM_PORTS-1:0] pop_o;
    logic flit_valid_o;
    logic [CW-1:0] credit_cnt_o;
    logic credit_err_o;
    modport master (
        output req_i, head_flit_i, credit_i,
        input grant_o, pop_o, flit_valid_o, credit_cnt_o, credit_err_o
    );
    modport slave (
        input req_i, head_flit_i, credit_i,
        output grant_o, pop_o, flit_valid_o, credit_cnt_o, credit_err_o
    );
endinterface

// File: rtl/xbar_out_alloc_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after rr_ptr, with wrap
module rr_arbiter #(
    parameter int N = 5,
    localparam int PW = $clog2(N)
) (
    input logic [N-1:0] req,
    input logic [PW-1:0] rr_ptr,
    output logic [N-1:0] gnt
);
    always_comb begin
        gnt = '0;
        // scan farthest-first so the nearest requester after rr_ptr overwrites last
        for (int k = N; k >= 1; k--) begin
            gnt = req[(int'(rr_ptr) + k) % N] ? N'(1) << ((int'(rr_ptr) + k) % N) : gnt;
        end
    end
endmodule

// File: rtl/xbar_out_alloc.sv
// xbar_out_alloc: per-output wormhole switch allocator with round-robin and credit tracking
module xbar_out_alloc
    import noc_pkg::*;
#(
    parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int CREDITS = noc_pkg::CREDITS
) (
    input logic clk,
    input logic rst,
    xbar_out_alloc_if.slave bus
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(CREDITS + 1);
    typedef enum logic {IDLE, LOCKED} state_e;
    state_e state;
    logic [PW-1:0] owner, rr_ptr, win_idx;
    logic [NUM_PORTS-1:0] elig, win, grant;
    logic [CW-1:0] cnt;
    logic err, pop_any, last;
    logic [FLIT_W-1:0] owner_flit;
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = bus.req_i[i] && (flit_type(bus.head_flit_i[i*FLIT_W +: FLIT_W]) inside {HEAD, HEAD_TAIL});
        end
    end
    rr_arbiter #(.N(NUM_PORTS)) u_arb (.req(elig), .rr_ptr(rr_ptr), .gnt(win));
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            win_idx = win[i] ? PW'(i) : win_idx;
        end
    end
    assign owner_flit = bus.head_flit_i[owner*FLIT_W +: FLIT_W];
    // grant is only non-zero while LOCKED, so it doubles as the owner mask
    assign bus.pop_o = grant & bus.req_i & {NUM_PORTS{cnt != '0}};
    assign pop_any = |bus.pop_o;
    assign last = pop_any && (flit_type(owner_flit) inside {TAIL, HEAD_TAIL});
    assign bus.grant_o = grant;
    assign bus.flit_valid_o = pop_any;
    assign bus.credit_cnt_o = cnt;
    assign bus.credit_err_o = err;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            rr_ptr <= PW'(NUM_PORTS - 1);
            cnt <= CW'(CREDITS);
            err <= 1'b0;
        end else begin
            cnt <= (pop_any && !bus.credit_i) ? cnt - CW'(1) :
                   (!pop_any && bus.credit_i && cnt != CW'(CREDITS)) ? cnt + CW'(1) : cnt;
            err <= err || (bus.credit_i && !pop_any && cnt == CW'(CREDITS));
            if (state == IDLE) begin
                if (|elig) begin
                    state <= LOCKED;
                    owner <= win_idx;
                    grant <= win;
                end
            end else if (last) begin
                state <= IDLE;
                rr_ptr <= owner;
                grant <= '0;
            end
        end
    end
endmodule

// File: tb/tb_xbar_out_alloc.sv
// tb_xbar_out_alloc: directed scenarios plus randomized traffic against a queue-level reference model
module tb_xbar_out_alloc;
    import noc_pkg::*;
    typedef logic [15:0] fq_t[$];
    logic clk, rst;
    fq_t q[5];
    bit en[5];
    bit cr;
    int passed, total;
    bit m_locked, m_err;
    int m_owner, m_rr, m_cnt;
    xbar_out_alloc_if bus();
    xbar_out_alloc dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 0;
    always #5 clk = ~clk;
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1);
    end
    function automatic logic [15:0] mk(flit_type_e t);
        return {t, 14'($urandom)};
    endfunction
    function automatic bit avail(int p);
        return en[p] && q[p].size() > 0;
    endfunction
    function automatic int model_winner();
        for (int k = 1; k <= 5; k++) begin
            int p;
            p = (m_rr + k) % 5;
            if (avail(p) && (flit_type(q[p][0]) == HEAD || flit_type(q[p][0]) == HEAD_TAIL)) return p;
        end
        return -1;
    endfunction
    function automatic int model_pop();
        return (m_locked && avail(m_owner) && m_cnt > 0) ? m_owner : -1;
    endfunction
    function automatic logic [4:0] exp_grant();
        return m_locked ? 5'(1 << m_owner) : 5'b0;
    endfunction
    function automatic logic [4:0] exp_pop();
        int p;
        p = model_pop();
        return p >= 0 ? 5'(1 << p) : 5'b0;
    endfunction
    task automatic drive();
        for (int i = 0; i < 5; i++) begin
            bus.req_i[i] = avail(i);
            bus.head_flit_i[i*16 +: 16] = q[i].size() > 0 ? q[i][0] : 16'h0;
        end
        bus.credit_i = cr;
    endtask
    task automatic tick();
        int pi, w;
        bit c;
        logic [15:0] ft;
        pi = model_pop();
        w = model_winner();
        c = bus.credit_i;
        ft = '0;
        @(posedge clk);
        if (pi >= 0) ft = q[pi].pop_front();
        if (rst) begin
            m_locked = 0; m_owner = 0; m_rr = 4; m_cnt = 4; m_err = 0;
        end else begin
            if (pi >= 0 && !c) m_cnt--;
            else if (pi < 0 && c) begin
                if (m_cnt == 4) m_err = 1;
                else m_cnt++;
            end
            if (m_locked) begin
                if (pi >= 0 && (flit_type(ft) == TAIL || flit_type(ft) == HEAD_TAIL)) begin
                    m_locked = 0;
                    m_rr = m_owner;
                end
            end else if (w >= 0) begin
                m_locked = 1;
                m_owner = w;
            end
        end
        @(negedge clk);
        drive();
        #1;
    endtask
    task automatic do_reset();
        rst = 1; cr = 0;
        for (int i = 0; i < 5; i++) begin
            q[i].delete();
            en[i] = 1;
        end
        drive();
        tick();
        tick();
        rst = 0;
        drive();
        #1;
    endtask
    task automatic test_reset();
        do_reset();
        tick();
        total++; if (bus.grant_o !== 5'b0) $display("FAIL reset_grant got %b want 00000", bus.grant_o); else passed++;
        total++; if (bus.pop_o !== 5'b0) $display("FAIL reset_pop got %b want 00000", bus.pop_o); else passed++;
        total++; if (bus.credit_cnt_o !== 3'd4) $display("FAIL reset_cnt got %0d want 4", bus.credit_cnt_o); else passed++;
        total++; if (bus.credit_err_o !== 1'b0) $display("FAIL reset_err got %b want 0", bus.credit_err_o); else passed++;
    endtask
    task automatic test_single_packet();
        do_reset();
        q[2].push_back(mk(HEAD)); q[2].push_back(mk(BODY)); q[2].push_back(mk(TAIL));
        drive();
        #1;
        total++; if (bus.grant_o !== 5'b0) $display("FAIL single_arb_cycle grant got %b want 00000", bus.grant_o); else passed++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (bus.grant_o !== 5'b00100) $display("FAIL single_grant[%0d] got %b want 00100", k, bus.grant_o); else passed++;
            total++; if (bus.pop_o !== 5'b00100) $display("FAIL single_pop[%0d] got %b want 00100", k, bus.pop_o); else passed++;
        end
        tick();
        total++; if (bus.grant_o !== 5'b0) $display("FAIL single_release got %b want 00000", bus.grant_o); else passed++;
        total++; if (bus.credit_cnt_o !== 3'd1) $display("FAIL single_cnt got %0d want 1", bus.credit_cnt_o); else passed++;
    endtask
    task automatic test_round_robin();
        int order[6] = '{0, 1, 4, 0, 1, 4};
        int n, cyc;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            q[0].push_back(mk(HEAD_TAIL)); q[1].push_back(mk(HEAD_TAIL)); q[4].push_back(mk(HEAD_TAIL));
        end
        cr = 1;
        drive();
        #1;
        n = 0; cyc = 0;
        while (n < 6 && cyc < 60) begin
            if (bus.pop_o !== 5'b0) begin
                total++; if (bus.pop_o !== 5'(1 << order[n])) $display("FAIL rr_order[%0d] got %b want %b", n, bus.pop_o, 5'(1 << order[n])); else passed++;
                total++; if (bus.credit_cnt_o !== 3'd4) $display("FAIL rr_cnt[%0d] got %0d want 4", n, bus.credit_cnt_o); else passed++;
                n++;
            end
            tick();
            cyc++;
        end
        total++; if (n != 6) $display("FAIL rr_timeout got %0d pops want 6", n); else passed++;
    endtask
    task automatic test_credit_stall();
        int n, cyc;
        do_reset();
        q[3].push_back(mk(HEAD));
        for (int k = 0; k < 4; k++) q[3].push_back(mk(BODY));
        q[3].push_back(mk(TAIL));
        drive();
        #1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 20) begin
            if (bus.pop_o !== 5'b0) n++;
            tick();
            cyc++;
        end
        total++; if (n != 4) $display("FAIL stall_first_pops got %0d want 4", n); else passed++;
        for (int k = 0; k < 3; k++) begin
            total++; if (bus.pop_o !== 5'b0) $display("FAIL stall_pop[%0d] got %b want 00000", k, bus.pop_o); else passed++;
            total++; if (bus.grant_o !== 5'b01000) $display("FAIL stall_grant[%0d] got %b want 01000", k, bus.grant_o); else passed++;
            total++; if (bus.credit_cnt_o !== 3'd0) $display("FAIL stall_cnt[%0d] got %0d want 0", k, bus.credit_cnt_o); else passed++;
            tick();
        end
        cr = 1;
        drive();
        cr = 0;
        tick();
        total++; if (bus.pop_o !== 5'b01000) $display("FAIL stall_resume_pop got %b want 01000", bus.pop_o); else passed++;
        total++; if (bus.credit_cnt_o !== 3'd1) $display("FAIL stall_resume_cnt got %0d want 1", bus.credit_cnt_o); else passed++;
        tick();
        for (int k = 0; k < 3; k++) begin
            total++; if (bus.pop_o !== 5'b0) $display("FAIL stall_after_pop[%0d] got %b want 00000", k, bus.pop_o); else passed++;
            total++; if (bus.credit_cnt_o !== 3'd0) $display("FAIL stall_after_cnt[%0d] got %0d want 0", k, bus.credit_cnt_o); else passed++;
            tick();
        end
    endtask
    task automatic test_lock_intruder();
        int cyc;
        do_reset();
        q[1].push_back(mk(HEAD)); q[1].push_back(mk(BODY)); q[1].push_back(mk(BODY)); q[1].push_back(mk(TAIL));
        q[2].push_back(mk(BODY));
        drive();
        tick();
        tick();
        q[0].push_back(mk(HEAD_TAIL));
        en[1] = 0;
        drive();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++; if (bus.grant_o !== 5'b00010) $display("FAIL lock_bubble_grant[%0d] got %b want 00010", k, bus.grant_o); else passed++;
            total++; if (bus.pop_o !== 5'b0) $display("FAIL lock_bubble_pop[%0d] got %b want 00000", k, bus.pop_o); else passed++;
            tick();
        end
        en[1] = 1;
        drive();
        #1;
        cyc = 0;
        while (q[1].size() > 0 && cyc < 20) begin
            total++; if (bus.grant_o !== 5'b00010) $display("FAIL lock_hold_grant got %b want 00010", bus.grant_o); else passed++;
            tick();
            cyc++;
        end
        total++; if (bus.grant_o !== 5'b0) $display("FAIL lock_after_tail got %b want 00000", bus.grant_o); else passed++;
        tick();
        total++; if (bus.grant_o !== 5'b00001) $display("FAIL lock_intruder_grant got %b want 00001", bus.grant_o); else passed++;
        do_reset();
        q[2].push_back(mk(BODY));
        q[4].push_back(mk(TAIL));
        drive();
        for (int k = 0; k < 3; k++) tick();
        total++; if (bus.grant_o !== 5'b0) $display("FAIL idle_body_wins got %b want 00000", bus.grant_o); else passed++;
    endtask
    task automatic test_errors_reset();
        do_reset();
        cr = 1;
        drive();
        cr = 0;
        tick();
        total++; if (bus.credit_err_o !== 1'b1) $display("FAIL err_set got %b want 1", bus.credit_err_o); else passed++;
        total++; if (bus.credit_cnt_o !== 3'd4) $display("FAIL err_cnt got %0d want 4", bus.credit_cnt_o); else passed++;
        tick();
        tick();
        total++; if (bus.credit_err_o !== 1'b1) $display("FAIL err_sticky got %b want 1", bus.credit_err_o); else passed++;
        do_reset();
        q[0].push_back(mk(HEAD_TAIL));
        drive();
        tick(); tick(); tick();
        q[2].push_back(mk(HEAD)); q[2].push_back(mk(BODY)); q[2].push_back(mk(BODY)); q[2].push_back(mk(TAIL));
        drive();
        tick(); tick();
        total++; if (bus.grant_o !== 5'b00100) $display("FAIL midpkt_grant got %b want 00100", bus.grant_o); else passed++;
        rst = 1;
        drive();
        tick();
        rst = 0;
        for (int i = 0; i < 5; i++) q[i].delete();
        drive();
        #1;
        total++; if (bus.grant_o !== 5'b0) $display("FAIL rst_mid_grant got %b want 00000", bus.grant_o); else passed++;
        total++; if (bus.credit_cnt_o !== 3'd4) $display("FAIL rst_mid_cnt got %0d want 4", bus.credit_cnt_o); else passed++;
        total++; if (bus.credit_err_o !== 1'b0) $display("FAIL rst_mid_err got %b want 0", bus.credit_err_o); else passed++;
        q[0].push_back(mk(HEAD_TAIL)); q[1].push_back(mk(HEAD_TAIL));
        drive();
        tick();
        total++; if (bus.grant_o !== 5'b00001) $display("FAIL rst_priority got %b want 00001", bus.grant_o); else passed++;
    endtask
    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int p, len;
                p = $urandom_range(0, 4);
                len = $urandom_range(1, 4);
                if (q[p].size() < 8) begin
                    if (len == 1) q[p].push_back(mk(HEAD_TAIL));
                    else begin
                        q[p].push_back(mk(HEAD));
                        for (int b = 0; b < len - 2; b++) q[p].push_back(mk(BODY));
                        q[p].push_back(mk(TAIL));
                    end
                end
            end
            for (int i = 0; i < 5; i++) en[i] = $urandom_range(0, 4) != 0;
            cr = m_cnt < 4 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            drive();
            #1;
            total++; if (bus.grant_o !== exp_grant()) $display("FAIL rand_grant c%0d got %b want %b", c, bus.grant_o, exp_grant()); else passed++;
            total++; if (bus.pop_o !== exp_pop()) $display("FAIL rand_pop c%0d got %b want %b", c, bus.pop_o, exp_pop()); else passed++;
            total++; if (bus.flit_valid_o !== (exp_pop() != 0)) $display("FAIL rand_valid c%0d got %b want %b", c, bus.flit_valid_o, exp_pop() != 0); else passed++;
            total++; if (bus.credit_cnt_o !== 3'(m_cnt)) $display("FAIL rand_cnt c%0d got %0d want %0d", c, bus.credit_cnt_o, m_cnt); else passed++;
            total++; if (bus.credit_err_o !== m_err) $display("FAIL rand_err c%0d got %b want %b", c, bus.credit_err_o, m_err); else passed++;
            total++;
            if (!$onehot0(bus.grant_o) || !$onehot0(bus.pop_o) || (bus.pop_o & ~bus.grant_o) != 0)
                $display("FAIL rand_invariant c%0d got grant %b pop %b want onehot0 with pop within grant", c, bus.grant_o, bus.pop_o);
            else passed++;
            tick();
        end
    endtask
    initial begin
        passed = 0; total = 0;
        rst = 1; cr = 0;
        m_locked = 0; m_owner = 0; m_rr = 4; m_cnt = 4; m_err = 0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_credit_stall();
        test_lock_intruder();
        test_errors_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
